// File: rtl/ioreg_master_if.sv
// ioreg_master_if: host request/response port and config bus strobes of ioreg_master
interface ioreg_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_all;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        config_write;
  logic        config_read;
  logic [1:0]  config_addr;
  modport master (
    input  req_valid, req_write, req_all, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, config_write, config_read, config_addr
  );
  modport slave (
    output req_valid, req_write, req_all, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, config_write, config_read, config_addr
  );
endinterface

// File: rtl/ioreg_master.sv
// ioreg_master: sequences single/all-register reads and writes on the shared 4 x 8-bit config bus
module ioreg_master #(
  parameter int unsigned TURNAROUND = 1
) (
  input  logic           reset,
  input  logic           config_clk,
  ioreg_master_if.master bus,
  inout  wire  [7:0]     config_data
);
  typedef enum logic [2:0] {IDLE, WRITE, RD_SETUP, RD_SAMPLE, TURN} state_t;
  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n, tcnt, tcnt_n, addr_n;
  logic        all_q, all_n, cfg_wr_n, cfg_rd_n, rsp_v_n;
  logic [31:0] wd_q, wd_n, rdata_n;
  logic [23:0] acc_q, acc_n;
  // the low byte of wd_q is always the byte currently on the bus
  assign config_data = bus.config_write ? wd_q[7:0] : 8'hzz;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tcnt_n   = tcnt;
    all_n    = all_q;
    wd_n     = wd_q;
    acc_n    = acc_q;
    rdata_n  = bus.rsp_rdata;
    addr_n   = bus.config_addr;
    cfg_wr_n = 1'b0;
    cfg_rd_n = 1'b0;
    rsp_v_n  = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n  = bus.req_write ? WRITE : RD_SETUP;
        all_n    = bus.req_all;
        cnt_n    = bus.req_all ? 2'd3 : 2'd0;
        wd_n     = bus.req_wdata;
        addr_n   = bus.req_all ? 2'd0 : bus.req_addr;
        cfg_wr_n = bus.req_write;
      end
      WRITE: if (cnt == 2'd0) begin
        state_n = IDLE;
        addr_n  = 2'd0;
        rsp_v_n = 1'b1;
      end else begin
        cnt_n    = cnt - 2'd1;
        addr_n   = bus.config_addr + 2'd1;
        wd_n     = wd_q >> 8;
        cfg_wr_n = 1'b1;
      end
      RD_SETUP: begin
        state_n  = RD_SAMPLE;
        cfg_rd_n = 1'b1;
        addr_n   = all_q ? bus.config_addr + 2'd1 : bus.config_addr;
      end
      // the responder output is one address behind config_addr, so the address saturates at 3
      RD_SAMPLE: if (cnt == 2'd0) begin
        state_n = TURNAROUND == 0 ? IDLE : TURN;
        tcnt_n  = 2'(TURNAROUND - 1);
        addr_n  = 2'd0;
        rsp_v_n = 1'b1;
        rdata_n = all_q ? {config_data, acc_q} : {24'h0, config_data};
      end else begin
        cnt_n    = cnt - 2'd1;
        acc_n    = {config_data, acc_q[23:8]};
        cfg_rd_n = 1'b1;
        addr_n   = bus.config_addr == 2'd3 ? 2'd3 : bus.config_addr + 2'd1;
      end
      TURN: if (tcnt == 2'd0) state_n = IDLE; else tcnt_n = tcnt - 2'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge config_clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 2'd0;
      tcnt             <= 2'd0;
      all_q            <= 1'b0;
      wd_q             <= 32'h0;
      acc_q            <= 24'h0;
      bus.req_ready    <= 1'b1;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= 32'h0;
      bus.config_write <= 1'b0;
      bus.config_read  <= 1'b0;
      bus.config_addr  <= 2'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      tcnt             <= tcnt_n;
      all_q            <= all_n;
      wd_q             <= wd_n;
      acc_q            <= acc_n;
      bus.req_ready    <= state_n == IDLE;
      bus.rsp_valid    <= rsp_v_n;
      bus.rsp_rdata    <= rdata_n;
      bus.config_write <= cfg_wr_n;
      bus.config_read  <= cfg_rd_n;
      bus.config_addr  <= addr_n;
    end
  end
endmodule

// File: tb/tb_ioreg_master.sv
// tb_ioreg_master: random and directed requests against a register-file responder and a reference model
module tb_ioreg_master;
  localparam int TA = 2;
  logic reset = 1'b1;
  logic config_clk = 1'b0;
  wire  [7:0] config_data;
  ioreg_master_if bus ();
  ioreg_master #(.TURNAROUND(TA)) dut (
    .reset(reset), .config_clk(config_clk), .bus(bus.master), .config_data(config_data)
  );
  always #5 config_clk = ~config_clk;

  logic [7:0] resp_mem [4];
  logic [7:0] resp_q;
  assign config_data = bus.config_read ? resp_q : 8'hzz;
  always @(posedge config_clk) begin
    if (bus.config_write) resp_mem[bus.config_addr] <= config_data;
    resp_q <= resp_mem[bus.config_addr];
  end

  typedef struct { logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { logic [1:0] a; logic [7:0] d; } wr_t;
  rsp_t exp_rsp [$];
  wr_t  exp_wr [$];
  logic [7:0]  ref_mem [4];
  logic [31:0] last_rd;
  int cyc = 0, checks = 0, errors = 0, last_rd_cyc = -100;
  logic prev_wr = 1'b0;

  always @(posedge config_clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  always @(negedge config_clk) begin
    if (reset) prev_wr = 1'b0;
    else begin
      rsp_t r;
      wr_t w;
      check("strobe_excl", 32'(bus.config_write & bus.config_read), 0);
      if (bus.req_ready) check("idle_addr", 32'(bus.config_addr), 0);
      if (bus.config_read) last_rd_cyc = cyc;
      if (bus.config_write && !prev_wr) check("turn_gap", 32'(cyc - last_rd_cyc > TA), 1);
      prev_wr = bus.config_write;
      if (bus.config_write) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.config_addr), 32'(w.a));
          check("wr_data", 32'(config_data), 32'(w.d));
        end
      end
      if (bus.rsp_valid) begin
        check("rsp_expected", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          check("rsp_rdata", bus.rsp_rdata, r.rdata);
          check("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic al, input logic [1:0] ad, input logic [31:0] wd);
    int n = 0;
    int ca;
    rsp_t r;
    wr_t x;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_all   = al;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    while (!bus.req_ready && n < 100) begin
      @(negedge config_clk);
      n++;
    end
    check("accept_timeout", 32'(bus.req_ready), 1);
    @(posedge config_clk);
    #1;
    ca = cyc;
    bus.req_valid = 1'b0;
    check("ready_drop", 32'(bus.req_ready), 0);
    if (w) begin
      for (int i = 0; i < (al ? 4 : 1); i++) begin
        x.a = al ? 2'(i) : ad;
        x.d = wd[8*i +: 8];
        ref_mem[x.a] = x.d;
        exp_wr.push_back(x);
      end
      r.rdata = last_rd;
      r.cyc   = ca + (al ? 4 : 1);
    end else begin
      r.rdata = al ? {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} : {24'h0, ref_mem[ad]};
      r.cyc   = ca + (al ? 5 : 2);
      last_rd = r.rdata;
    end
    exp_rsp.push_back(r);
  endtask

  task automatic scramble();
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'($urandom);
      bus.req_all   = 1'($urandom);
      bus.req_addr  = 2'($urandom);
      bus.req_wdata = $urandom;
      @(negedge config_clk);
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 200) begin
      @(negedge config_clk);
      n++;
    end
    check("drain", 32'(exp_rsp.size()), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_wr"}, 32'(bus.config_write), 0);
    check({tag, "_rd"}, 32'(bus.config_read), 0);
    check({tag, "_addr"}, 32'(bus.config_addr), 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_all   = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_wdata = 32'h0;
    last_rd = 32'h0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h0;
    repeat (2) @(posedge config_clk);
    #1;
    check_reset_outputs("reset");
    @(negedge config_clk);
    reset = 1'b0;
    issue(1'b1, 1'b1, 2'd0, 32'h0);
    issue(1'b1, 1'b0, 2'd2, 32'h000000A5);
    issue(1'b0, 1'b0, 2'd2, 32'h0);
    drain();
    check("single_rd_a5", bus.rsp_rdata, 32'h000000A5);
    issue(1'b1, 1'b1, 2'd0, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    drain();
    check("all_rd_deadbeef", bus.rsp_rdata, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 2'd3, 32'h0);
    issue(1'b1, 1'b0, 2'd1, 32'h00000077);
    drain();
    check("rdata_held", bus.rsp_rdata, 32'h000000DE);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    issue(1'b1, 1'b0, 2'd0, 32'h0000005A);
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    scramble();
    issue(1'b0, 1'b0, 2'd0, 32'h0);
    drain();
    issue(1'b1, 1'b1, 2'd0, 32'h0);
    issue(1'b1, 1'b1, 2'd0, 32'h11223344);
    @(posedge config_clk);
    @(posedge config_clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_wr.delete();
    exp_rsp.delete();
    ref_mem[2] = 8'h00;
    ref_mem[3] = 8'h00;
    last_rd = 32'h0;
    @(negedge config_clk);
    reset = 1'b0;
    issue(1'b0, 1'b1, 2'd0, 32'h0);
    drain();
    check("partial_write", bus.rsp_rdata, 32'h00003344);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) scramble();
      issue(1'($urandom), 1'($urandom), 2'($urandom), $urandom);
    end
    drain();
    check("wr_leftover", 32'(exp_wr.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ioreg_master.md
# ioreg_master

Bus initiator for the 4 x 8-bit configuration register interface (config_write / config_read / config_addr / config_data). Accepts single-byte or whole-word (all four registers) read and write requests from a host-side valid/ready port and sequences the shared tri-state config bus accordingly. It returns read data as a 32-bit word with a one-cycle response pulse. Sits on the host side of the config bus, in the config_clk domain, opposite the register-file responder.

## Interface
- TURNAROUND, 1: idle bus cycles after any read before the master may drive config_data again (0..3).
- reset  in  1  reset, asynchronous, active-high
- config_clk  in  1  clock config_clk
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_all  in  1  1 = operate on all four registers; 0 = single register at req_addr
- req_addr  in  2  register index for single operations (ignored when req_all=1)
- req_wdata  in  32  write data; byte g goes to register g for all-writes; [7:0] for single writes
- rsp_valid  out  1  one-cycle pulse: operation complete
- rsp_rdata  out  32  read result; single read returns {24'h0, byte}; held until the next read completes
- config_write  out  1  bus write strobe
- config_read  out  1  bus read enable; the responder drives config_data while this is high
- config_addr  out  2  bus register address
- config_data  inout  8  bus data; driven by the master only while config_write=1, else high-Z

## Operation
- States: IDLE, WRITE, RD_SETUP, RD_SAMPLE, TURN.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid && req_ready. req_ready=0 in every other state.
- WRITE: config_write=1, config_addr=a, config_data=byte. A single write takes 1 cycle. An all-write takes 4 consecutive cycles with a=0,1,2,3 and byte=req_wdata[8a+7:8a]. After the last WRITE cycle: IDLE, rsp_valid=1. rsp_rdata is unchanged.
- RD_SETUP: 1 cycle. config_addr=first address (req_addr, or 0 for all). config_read=0. The responder latches its output register at the end of this cycle.
- RD_SAMPLE: config_read=1, 1 cycle per byte (1 or 4).
  - The master samples config_data at the end of each cycle.
  - config_addr is advanced to the next address during each sample cycle, giving 1,2,3,3 for an all-read, so the responder's output is pipelined.
  - Byte k is stored into rsp_rdata[8k+7:8k]. A single read stores into [7:0] and clears [31:8].
- TURN: config_read=0, master not driving. Lasts TURNAROUND cycles, then IDLE. With TURNAROUND=0, go directly to IDLE.
- rsp_valid is asserted in the first cycle after the last RD_SAMPLE cycle (TURN, or IDLE if TURNAROUND=0). rsp_rdata is valid in that same cycle.
- Captured request fields are registered at acceptance. Input changes during an operation have no effect.
- Invariants:
  - config_write && config_read is never 1.
  - The master output enable is never active while config_read=1 or in TURN.
  - config_addr=0 in IDLE.

## Timing
- Reset (asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, config_write=0, config_read=0, config_addr=0, config_data high-Z.
- Reset asserted mid-operation: the bus is released immediately (not at the next edge). No rsp_valid. Partially written registers keep their values.
- All outputs are registered from config_clk except config_data tri-state (enable = registered config_write).
- Latency, with accept at edge E0:
  - Single write: config_write high E0–E1; rsp_valid E1–E2; req_ready high from E1.
  - All-write: config_write high E0–E4; rsp_valid E4–E5; req_ready high from E4.
  - Single read: setup E0–E1; sample E1–E2; rsp_valid E2–E3; req_ready high from E2+TURNAROUND.
  - All-read: setup E0–E1; samples E1–E5; rsp_valid E5–E6; req_ready high from E5+TURNAROUND.
- Back-to-back: a request held valid in the IDLE cycle carrying rsp_valid is accepted at that edge. There is no request queueing.

## Test plan
- Reset release, then single write addr 2 data 8'hA5: config_write high exactly 1 cycle with addr 2, data A5. rsp_valid 1 cycle later. A subsequent single read of addr 2 returns rsp_rdata=32'h000000A5.
- All-write 32'hDEADBEEF, then all-read: 4 write cycles with addr 0..3 and bytes EF,BE,AD,DE. The read returns rsp_rdata=32'hDEADBEEF with rsp_valid at E5 after acceptance.
- TURNAROUND=2, all-read immediately followed by a queued write (req_valid held high): the write's config_write rises no earlier than 2 cycles after config_read falls. Bus monitor sees no cycle with both strobes high or with two drivers.
- Reset pulse during the third cycle of an all-write: all outputs at reset values asynchronously, no rsp_valid. The responder holds bytes 0 and 1 written and bytes 2 and 3 cleared.
- Single read of addr 3 after the all-write 32'hDEADBEEF: rsp_rdata=32'h000000DE, the upper bytes cleared. A following single write leaves rsp_rdata unchanged.
- req_valid held with changing req_addr/req_wdata during a busy all-read: only the values present at the acceptance edge are used. req_ready stays 0 until IDLE.
